// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface rr_onehot_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot (or zero) grant with
// bounded tenure: done, requester drop or hold-limit forced release.
module rr_onehot_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_onehot_arbiter_if.slave   bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          win_found_s;
  logic [PW-1:0] win_idx_s;
  logic          rel_done_s;
  logic          rel_drop_s;
  logic          rel_limit_s;

  // Rotating search: first asserted request at or above ptr, wrapping to 0.
  always_comb begin
    logic [PW-1:0] idx;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!win_found_s && bus.req[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Since gnt_q is one-hot while granting, masking req with it isolates req[g].
  always_comb begin
    rel_done_s  = bus.done;
    rel_drop_s  = ~(|(bus.req & gnt_q));
    rel_limit_s = (cnt_q == CW'(MAX_HOLD - 1));
  end

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          gnt_d   = N'(1) << win_idx_s;
          ptr_d   = (win_idx_s == PW'(N - 1)) ? '0 : (win_idx_s + PW'(1));
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel_done_s || rel_drop_s || rel_limit_s) begin
          gnt_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
          timeout_d = rel_limit_s && !rel_done_s && !rel_drop_s;
        end else begin
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Vector-table and scoreboard bench for rr_onehot_arbiter: expectations are
// queued when inputs are driven and checked one clock later.
module tb_rr_onehot_arbiter;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       to;
    string      tag;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic       to;
    string      tag;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_onehot_arbiter_if #(.N(8)) bus ();

  rr_onehot_arbiter #(.N(8), .MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_drv = 0;

  task automatic add(input logic r, input logic [7:0] rq, input logic d,
                     input logic [7:0] g, input logic t, input string tag);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.gnt = g; v.to = t; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] g, input logic t, input string tag);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    e.gnt = g; e.to = t; e.tag = tag; e.id = n_drv;
    n_drv++;
    sb.push_back(e);
  endtask

  // Checker: pops one expectation per clock and checks the grant invariants.
  initial begin
    exp_t e;
    int   pc;
    forever begin
      @(posedge clk);
      #1;
      pc = $countones(bus.gnt);
      if (pc > 1) begin
        n_err++;
        $display("FAIL onehot t=%0t: gnt=%h popcount=%0d want <=1", $time, bus.gnt, pc);
      end
      if (bus.gnt_valid !== (|bus.gnt)) begin
        n_err++;
        $display("FAIL valid_eq t=%0t: gnt_valid=%b want %b", $time, bus.gnt_valid, |bus.gnt);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (bus.gnt !== e.gnt) begin
          n_err++;
          $display("FAIL %s #%0d gnt: got %h want %h", e.tag, e.id, bus.gnt, e.gnt);
        end
        if (bus.gnt_valid !== (|e.gnt)) begin
          n_err++;
          $display("FAIL %s #%0d gnt_valid: got %b want %b", e.tag, e.id, bus.gnt_valid, |e.gnt);
        end
        if (bus.timeout !== e.to) begin
          n_err++;
          $display("FAIL %s #%0d timeout: got %b want %b", e.tag, e.id, bus.timeout, e.to);
        end
      end
    end
  end

  initial begin
    logic [7:0] one;
    one      = 8'h01;
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // Reset held with all requests pending, then first grant from ptr=0.
    add(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, "reset");
    add(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, "reset");
    add(1'b0, 8'hFF, 1'b0, 8'h01, 1'b0, "first_gnt");
    // Round robin with done one cycle after each grant.
    for (int k = 1; k < 8; k++) begin
      add(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, "rr_gap");
      add(1'b0, 8'hFF, 1'b0, one << k, 1'b0, "rr_gnt");
    end
    add(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, "rr_gap");
    add(1'b0, 8'hFF, 1'b0, 8'h01, 1'b0, "rr_wrap");
    add(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, "rr_gap");
    // Single request after a fresh reset.
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "reset2");
    add(1'b0, 8'h04, 1'b0, 8'h04, 1'b0, "single");
    add(1'b0, 8'h04, 1'b1, 8'h00, 1'b0, "single_done");
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "single_idle");
    add(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, "idle_done");
    // Wrap and skip: grant bit 6 leaves ptr=7, then req=03 wraps to bit 0.
    add(1'b0, 8'h40, 1'b0, 8'h40, 1'b0, "bit6");
    add(1'b0, 8'h40, 1'b1, 8'h00, 1'b0, "bit6_done");
    add(1'b0, 8'h03, 1'b0, 8'h01, 1'b0, "wrap0");
    add(1'b0, 8'h03, 1'b1, 8'h00, 1'b0, "wrap0_done");
    add(1'b0, 8'h03, 1'b0, 8'h02, 1'b0, "skip1");
    // Requester drop releases, then search from ptr=2 wraps to bit 0.
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, "drop");
    add(1'b0, 8'h01, 1'b0, 8'h01, 1'b0, "drop_regnt");
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "drop2");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].to, vecs[i].tag);

    // Hold limit: 16 cycles of grant, forced release with timeout, regrant.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0, "hold");
    step(1'b0, 8'h10, 1'b0, 8'h00, 1'b1, "timeout");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0, "hold2");
    step(1'b0, 8'h10, 1'b1, 8'h00, 1'b0, "limit_with_done");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "after_limit");

    // Reset mid-grant: ptr=5 so req=FF grants bit 5; reset at cnt=5.
    for (int i = 0; i < 6; i++) step(1'b0, 8'hFF, 1'b0, 8'h20, 1'b0, "mid_gnt");
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, "mid_rst");
    step(1'b0, 8'hFF, 1'b0, 8'h01, 1'b0, "post_rst");
    step(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, "post_rst_done");

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
